// File: rtl/free_list_ctrl.sv
// Physical-register free list: circular FIFO of free indices with 2-wide allocate and 2-wide reclaim.
// Optional FREE_LIST_CHECK_EN builds the in-list bitvector (double-free filter) and the sticky err output.
module free_list_ctrl #(
  parameter int unsigned NUM_PREGS = 64,
  parameter int unsigned NUM_AREGS = 32,
  parameter int unsigned PREG_W    = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           alloc_req,
  output logic                 alloc_grant,
  output logic [PREG_W-1:0]    alloc_reg_1,
  output logic [PREG_W-1:0]    alloc_reg_2,
  input  logic [NUM_PREGS-1:0] free_mask,
  output logic [PREG_W:0]      free_count,
  output logic                 empty
`ifdef FREE_LIST_CHECK_EN
  ,
  output logic                 err
`endif
);

  localparam int unsigned CNT_W     = PREG_W + 1;
  localparam int unsigned INIT_FREE = NUM_PREGS - NUM_AREGS;

  logic [PREG_W-1:0]    fifo [NUM_PREGS];
  logic [PREG_W-1:0]    head;
  logic [PREG_W-1:0]    tail;
  logic [1:0]           req_n;
  logic [CNT_W-1:0]     granted;
  logic [CNT_W-1:0]     space;
  logic [CNT_W-1:0]     count_next;
  logic [NUM_PREGS-1:0] cand;
  logic [1:0]           found;
  logic [1:0]           accepted;
  logic [PREG_W-1:0]    idx_1;
  logic [PREG_W-1:0]    idx_2;

  // Allocation decision uses only the registered count; same-cycle frees never bypass.
  assign req_n       = (alloc_req == 2'd3) ? 2'd2 : alloc_req;
  assign alloc_grant = !reset && (req_n != 2'd0) && (free_count >= CNT_W'(req_n));
  assign alloc_reg_1 = fifo[head];
  assign alloc_reg_2 = fifo[head + PREG_W'(1)];
  assign granted     = alloc_grant ? CNT_W'(req_n) : '0;

`ifdef FREE_LIST_CHECK_EN
  logic [NUM_PREGS-1:0] in_list;
  logic [NUM_PREGS-1:0] in_list_next;
  logic                 err_hit;

  assign cand    = free_mask & ~in_list & ~NUM_PREGS'(1);
  assign err_hit = (|(free_mask & in_list)) | free_mask[0] | ($countones(free_mask) > 2);

  always_comb begin
    in_list_next = in_list;
    if (alloc_grant) begin
      in_list_next[alloc_reg_1] = 1'b0;
      if (req_n == 2'd2) in_list_next[alloc_reg_2] = 1'b0;
    end
    if (accepted != 2'd0) in_list_next[idx_1] = 1'b1;
    if (accepted == 2'd2) in_list_next[idx_2] = 1'b1;
  end
`else
  assign cand = free_mask & ~NUM_PREGS'(1);
`endif

  // Pick the lowest two candidate bits, lowest first.
  always_comb begin
    found = 2'd0;
    idx_1 = '0;
    idx_2 = '0;
    for (int unsigned i = 1; i < NUM_PREGS; i++) begin
      if (cand[i]) begin
        if (found == 2'd0)      idx_1 = PREG_W'(i);
        else if (found == 2'd1) idx_2 = PREG_W'(i);
        if (found != 2'd2)      found = found + 2'd1;
      end
    end
  end

  // Never let occupancy exceed the FIFO depth, even when double frees go unfiltered.
  always_comb begin
    space      = CNT_W'(NUM_PREGS) - free_count + granted;
    accepted   = (CNT_W'(found) > space) ? space[1:0] : found;
    count_next = free_count - granted + CNT_W'(accepted);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PREGS; i++) begin
        fifo[i] <= (i < INIT_FREE) ? PREG_W'(i + NUM_AREGS) : '0;
`ifdef FREE_LIST_CHECK_EN
        in_list[i] <= (i >= NUM_AREGS);
`endif
      end
      head       <= '0;
      tail       <= PREG_W'(INIT_FREE);
      free_count <= CNT_W'(INIT_FREE);
      empty      <= (INIT_FREE == 0);
`ifdef FREE_LIST_CHECK_EN
      err        <= 1'b0;
`endif
    end else begin
      if (accepted != 2'd0) fifo[tail]               <= idx_1;
      if (accepted == 2'd2) fifo[tail + PREG_W'(1)]  <= idx_2;
      head       <= head + PREG_W'(granted);
      tail       <= tail + PREG_W'(accepted);
      free_count <= count_next;
      empty      <= (count_next == '0);
`ifdef FREE_LIST_CHECK_EN
      in_list    <= in_list_next;
      err        <= err | err_hit;
`endif
    end
  end

endmodule

// File: tb/tb_free_list_ctrl.sv
// Directed bench for free_list_ctrl: reset image, drain, refill, boundaries, wrap and error flagging.
module tb_free_list_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  alloc_req;
  logic        alloc_grant;
  logic [5:0]  alloc_reg_1;
  logic [5:0]  alloc_reg_2;
  logic [63:0] free_mask;
  logic [6:0]  free_count;
  logic        empty;
`ifdef FREE_LIST_CHECK_EN
  logic        err;
`endif

  int errors = 0;
  int checks = 0;

  free_list_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .alloc_req   (alloc_req),
    .alloc_grant (alloc_grant),
    .alloc_reg_1 (alloc_reg_1),
    .alloc_reg_2 (alloc_reg_2),
    .free_mask   (free_mask),
    .free_count  (free_count),
    .empty       (empty)
`ifdef FREE_LIST_CHECK_EN
    ,
    .err         (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int q[$];
    int prev;
    int got;
    int base;

    reset = 1'b1; alloc_req = 2'd0; free_mask = '0;
    cyc();
    // Requests and frees are ignored while reset is held.
    alloc_req = 2'd2; free_mask = 64'h30;
    #1 chk("grant_in_reset", alloc_grant, 0);
    cyc();
    chk("count_reset", free_count, 32);
    chk("empty_reset", empty, 0);
    reset = 1'b0; alloc_req = 2'd0; free_mask = '0;
`ifdef FREE_LIST_CHECK_EN
    chk("err_reset", err, 0);
`endif

    // First double allocation hands out p32/p33.
    alloc_req = 2'd2;
    #1;
    chk("grant_first", alloc_grant, 1);
    chk("reg1_first", alloc_reg_1, 32);
    chk("reg2_first", alloc_reg_2, 33);
    cyc();
    chk("count_after_first", free_count, 30);

    // Drain the remaining 30 entries two at a time.
    for (int i = 1; i < 16; i++) begin
      #1;
      chk("grant_drain", alloc_grant, 1);
      chk("reg1_drain", alloc_reg_1, 32 + 2 * i);
      chk("reg2_drain", alloc_reg_2, 33 + 2 * i);
      cyc();
    end
    chk("count_drained", free_count, 0);
    chk("empty_drained", empty, 1);
    alloc_req = 2'd1;
    #1 chk("grant_empty", alloc_grant, 0);

    // Frees in the same cycle as a request on an empty list do not bypass.
    free_mask = (64'd1 << 5) | (64'd1 << 9);
    #1 chk("grant_no_bypass", alloc_grant, 0);
    cyc();
    free_mask = '0;
    chk("count_refill", free_count, 2);
    chk("empty_refill", empty, 0);
    #1;
    chk("grant_p5", alloc_grant, 1);
    chk("reg1_p5", alloc_reg_1, 5);
    cyc();
    chk("count_one", free_count, 1);
    alloc_req = 2'd2;
    #1;
    chk("grant_short", alloc_grant, 0);
    chk("reg1_hold", alloc_reg_1, 9);
    cyc();
    chk("count_hold", free_count, 1);
    chk("reg1_after_hold", alloc_reg_1, 9);
    alloc_req = 2'd1;
    #1 chk("grant_p9", alloc_grant, 1);
    cyc();
    chk("count_zero_again", free_count, 0);
    alloc_req = 2'd0;

    // Refill p10..p17 in pairs.
    for (int r = 10; r < 18; r += 2) begin
      free_mask = (64'd1 << r) | (64'd1 << (r + 1));
      q.push_back(r);
      q.push_back(r + 1);
      cyc();
    end
    free_mask = '0;
    chk("count_refilled", free_count, 8);

    // Steady alloc-one/free-one across the index wrap; FIFO order must hold.
    prev = 20;
    for (int k = 0; k < 100; k++) begin
      alloc_req = 2'd1;
      free_mask = 64'd1 << prev;
      #1;
      got = q.pop_front();
      chk("grant_wrap", alloc_grant, 1);
      chk("reg1_wrap", alloc_reg_1, got);
      q.push_back(prev);
      prev = got;
      cyc();
      chk("count_wrap", free_count, 8);
    end
    alloc_req = 2'd0; free_mask = '0;
    #1 chk("reg1_after_wrap", alloc_reg_1, q[0]);

    // p0 is never reclaimed.
    free_mask = 64'd1;
    cyc();
    free_mask = '0;
    chk("count_bit0", free_count, 8);
`ifdef FREE_LIST_CHECK_EN
    chk("err_bit0", err, 1);
`endif

    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("count_rereset", free_count, 32);
`ifdef FREE_LIST_CHECK_EN
    chk("err_cleared", err, 0);
    base = 32;
`else
    base = 33;
`endif

    // p40 is already free: filtered and flagged when checking, enqueued otherwise.
    free_mask = 64'd1 << 40;
    cyc();
    chk("count_dbl_free", free_count, base);
`ifdef FREE_LIST_CHECK_EN
    chk("err_dbl_free", err, 1);
`endif
    // Bit 0 dropped, p1/p2 accepted.
    free_mask = 64'h7;
    cyc();
    chk("count_mask7", free_count, base + 2);
    // Three bits: only p3 and p4 taken.
    free_mask = (64'd1 << 3) | (64'd1 << 4) | (64'd1 << 6);
    cyc();
    free_mask = '0;
    chk("count_three_bits", free_count, base + 4);
`ifdef FREE_LIST_CHECK_EN
    chk("err_held", err, 1);
`endif

    reset = 1'b1;
    cyc();
    reset = 1'b0;
`ifdef FREE_LIST_CHECK_EN
    chk("err_reset_again", err, 0);
`endif
    // A request of 3 behaves as 2.
    alloc_req = 2'd3;
    #1;
    chk("grant_req3", alloc_grant, 1);
    chk("reg1_req3", alloc_reg_1, 32);
    chk("reg2_req3", alloc_reg_2, 33);
    cyc();
    alloc_req = 2'd0;
    chk("count_req3", free_count, 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
